// File: rtl/flash_ctrl_pkg.sv
// flash_ctrl_pkg
// Shared definitions for the SPI flash read controller: FSM state type,
// the flash READ opcode, transfer geometry and small framing helpers.
package flash_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0]  CMD_READ  = 8'h03;
  // SCK rising edges per transfer: 8 command + 24 address + 32 data.
  localparam int unsigned NUM_EDGES = 64;
  // Command/address bits shifted out before read data starts arriving.
  localparam int unsigned TX_BITS   = 32;

  // Command word sent on MOSI; reads are word aligned, so addr[1:0] is dropped.
  function automatic logic [31:0] read_cmd(input logic [23:0] addr);
    return {CMD_READ, addr[23:2], 2'b00};
  endfunction

  // The first byte received is the lowest address; present it in bits [7:0].
  function automatic logic [31:0] byte_swap(input logic [31:0] rx);
    return {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// spi_sck_gen
// SCK generator: counts CLK_DIV-cycle half-periods while run is high and
// toggles sck at the end of each one. rise_tick / fall_tick mark the last
// cycle of a low / high half-period, i.e. the cycle whose closing clock
// edge makes sck rise / fall.
// Ports:
//   clock, reset          system clock, asynchronous active-high reset
//   load                  restart: sck low, fresh half-period
//   run                   advance the half-period counter
//   sck                   SPI clock (mode 0, idles low)
//   rise_tick, fall_tick  edge strobes for the controller FSM
module spi_sck_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic run,
  output logic sck,
  output logic rise_tick,
  output logic fall_tick
);

  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

  logic [7:0] half_cnt;
  logic       tick;

  // With CLK_DIV=1 the counter sits at zero, so every running cycle ticks.
  assign tick      = run && (half_cnt == '0);
  assign rise_tick = tick && !sck;
  assign fall_tick = tick && sck;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      half_cnt <= '0;
      sck      <= 1'b0;
    end else if (load) begin
      half_cnt <= RELOAD;
      sck      <= 1'b0;
    end else if (run) begin
      if (tick) begin
        half_cnt <= RELOAD;
        sck      <= ~sck;
      end else begin
        half_cnt <= half_cnt - 8'd1;
      end
    end
  end

endmodule

// File: rtl/flash_read_ctrl.sv
// flash_read_ctrl
// Reads one 32-bit little-endian word from a SPI NOR flash with the 0x03
// READ command (mode 0). One request is handled at a time.
// Ports:
//   clock, reset            system clock, asynchronous active-high reset
//   req_valid/req_ready     request handshake, req_addr = flash byte address
//   resp_valid/resp_ready   response handshake, resp_data = word read
//   spi_sck/spi_ss          SPI clock (idle low), chip select (active low)
//   spi_mosi/spi_miso       serial command/address out, data in
module flash_read_ctrl
  import flash_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        spi_sck,
  output logic        spi_ss,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  state_t      state;
  state_t      state_next;
  logic        shifting;
  logic        handshake;
  logic        rise_tick;
  logic        fall_tick;
  logic        last_edge;
  logic [6:0]  edge_cnt;
  logic [31:0] tx;
  logic [31:0] rx;
  logic        ss;

  assign handshake = req_valid && req_ready;
  // edge_cnt indexes the current SCK period; it advances on each falling edge.
  assign last_edge = fall_tick && (edge_cnt == 7'(NUM_EDGES - 1));

  spi_sck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sck_gen (
    .clock    (clock),
    .reset    (reset),
    .load     (handshake),
    .run      (shifting),
    .sck      (spi_sck),
    .rise_tick(rise_tick),
    .fall_tick(fall_tick)
  );

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (handshake)  state_next = SHIFT;
      SHIFT:   if (last_edge)  state_next = DONE;
      DONE:    if (resp_ready) state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    shifting   = 1'b0;
    unique case (state)
      IDLE:    req_ready  = 1'b1;
      SHIFT:   shifting   = 1'b1;
      DONE:    resp_valid = 1'b1;
      default: ;
    endcase
  end

  // Shift datapath. The TX register shifts in zeros, so MOSI is low once
  // the 32 command/address bits are gone. spi_ss comes straight from a
  // register with asynchronous preset, so reset deselects the flash at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      edge_cnt  <= '0;
      tx        <= '0;
      rx        <= '0;
      ss        <= 1'b1;
      resp_data <= '0;
    end else if (handshake) begin
      edge_cnt <= '0;
      tx       <= read_cmd(req_addr);
      rx       <= '0;
      ss       <= 1'b0;
    end else if (rise_tick) begin
      if (edge_cnt >= 7'(TX_BITS)) begin
        rx <= {rx[30:0], spi_miso};
      end
    end else if (fall_tick) begin
      if (last_edge) begin
        edge_cnt  <= '0;
        ss        <= 1'b1;
        resp_data <= byte_swap(rx);
      end else begin
        edge_cnt <= edge_cnt + 7'd1;
        tx       <= {tx[30:0], 1'b0};
      end
    end
  end

  assign spi_ss   = ss;
  assign spi_mosi = tx[31];

endmodule

// File: doc/flash_read_ctrl.md
FLASH_READ_CTRL -- requirements
Module: flash_read_ctrl

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 2, giving the SCK half-period in clock cycles (legal range 1..255).
REQ-002 The block SHALL have port clock  input  1  system clock, with all state on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port req_valid  input  1  read request present.
REQ-005 The block SHALL have port req_ready  output  1  request accepted when high together with req_valid.
REQ-006 The block SHALL have port req_addr  input  24  flash byte address.
REQ-007 The block SHALL have port resp_valid  output  1  read data available.
REQ-008 The block SHALL have port resp_ready  input  1  consumer takes data.
REQ-009 The block SHALL have port resp_data  output  32  read word, little-endian.
REQ-010 The block SHALL have port spi_sck  output  1  SPI clock, idle low (mode 0).
REQ-011 The block SHALL have port spi_ss  output  1  active-low chip select, idle high.
REQ-012 The block SHALL have port spi_mosi  output  1  serial command and address, MSB first.
REQ-013 The block SHALL have port spi_miso  input  1  serial data from the flash.

Function
REQ-014 The state machine SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-015 req_ready SHALL be high only in IDLE; the handshake cycle is the cycle with req_valid and req_ready both high.
REQ-016 On the handshake the block SHALL load a 32-bit TX shift register with {8'h03, req_addr[23:2], 2'b00}, so bits [1:0] are forced to 0.
REQ-017 On the handshake the block SHALL drive spi_ss=0, spi_sck=0 and spi_mosi=TX[31], and enter SHIFT.
REQ-018 SHIFT SHALL run 128 half-periods of CLK_DIV cycles each, alternating SCK low then high, giving 64 SCK rising edges (8 command, 24 address, 32 data).
REQ-019 In the last cycle of each low half-period the block SHALL drive spi_sck 0->1 and sample spi_miso into a 32-bit RX shift register, but only for rising edges 33..64.
REQ-020 In the last cycle of each high half-period the block SHALL drive spi_sck 1->0 and shift TX left, so spi_mosi changes only while SCK falls.
REQ-021 After the 32nd TX bit, spi_mosi SHALL be held at 0.
REQ-022 At the end of the 128th half-period the block SHALL drive spi_ss=1 and spi_sck=0, set resp_data={RX[7:0],RX[15:8],RX[23:16],RX[31:24]}, assert resp_valid and enter DONE.
REQ-023 The edge counter SHALL be 7 bits wide, counting 0..63; the half-period counter SHALL be 8 bits wide and reload to CLK_DIV-1.
REQ-024 resp_valid SHALL first be high exactly 128*CLK_DIV+1 cycles after the handshake cycle.
REQ-025 In DONE, resp_data and resp_valid SHALL stay stable until resp_ready is high; resp_valid SHALL then clear and the state SHALL return to IDLE on the next edge.
REQ-026 spi_ss SHALL stay high for at least 2 clock cycles between any two transfers (DONE plus IDLE).
REQ-027 req_valid SHALL be ignored outside IDLE, and req_addr SHALL NOT be sampled after the handshake.
REQ-028 If CLK_DIV=1, the block SHALL produce an SCK that toggles every cycle with no loss of bits.

Reset
REQ-029 When reset is asserted, the block SHALL set state=IDLE, spi_ss=1, spi_sck=0, spi_mosi=0, resp_valid=0, resp_data=0, clear all counters and shift registers, and hold req_ready=1.
REQ-030 Reset asserted mid-transfer SHALL raise spi_ss immediately, without waiting for a clock edge, which aborts the flash transaction; no response SHALL be produced for the aborted request.

Structure
REQ-031 Shared package flash_ctrl_pkg SHALL hold the state enum (IDLE/SHIFT/DONE), CMD_READ=8'h03 and NUM_EDGES=64.
REQ-032 The half-period counter and SCK toggle SHALL live in one sub-module, spi_sck_gen, which outputs a rise_tick and a fall_tick to the FSM.

Verification (bench = flash_read_ctrl + the SPI flash model, with the DPI flash_read backed by a preloaded memory)
REQ-033 Read addr 0x000100 where the memory word is 0xDEADBEEF, CLK_DIV=2 -> MOSI carries 0x03 then 0x000100, 64 SCK rises, resp_valid 257 cycles after the handshake, resp_data=0xDEADBEEF.
REQ-034 Read addr 0x000103 -> MOSI address field 0x000100, resp_data equals the word at 0x100.
REQ-035 Hold resp_ready low for 10 cycles after resp_valid -> resp_data stable, req_ready=0, spi_ss=1 throughout.
REQ-036 Back-to-back reads of 0x0 (0x11223344) and 0x4 (0x55667788) with req_valid held high -> both returned in order, spi_ss high for at least 2 cycles between them.
REQ-037 Assert reset during the address phase (after 15 SCK rises), then read 0x8 -> spi_ss rises asynchronously, no resp_valid for the aborted read, and the next read returns the correct word.
REQ-038 Set CLK_DIV=1 and read 0x0 -> resp_valid 129 cycles after the handshake with correct data.
